yzb_istek_sirayici: RTL

//  Initiator for the yapay zeka (dot-product) unit's uop port. Takes one command (vector length L),

---
 rtl/yzb_istek_sirayici_if.sv | 40 ++++
 rtl/yzb_istek_sirayici.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/yzb_istek_sirayici_if.sv
// -----------------------------------------------------------------------------
// yzb_istek_sirayici_if
// Uop port between the request sequencer (master) and the dot-product unit
// (slave). Signal names keep the sequencer's point of view.
//   yzb_gecerli_o  master->slave  uop valid
//   yzb_kod_o      master->slave  uop code
//   yzb_islec1_o   master->slave  operand 1
//   yzb_islec2_o   master->slave  operand 2
//   yzb_gecerli_i  slave->master  unit done/accept; uop retires on valid && this
//   yzb_sonuc_i    slave->master  accumulated dot product from the unit
// -----------------------------------------------------------------------------
interface yzb_istek_sirayici_if #(
    parameter int VERI_BIT = 32,
    parameter int UOP_BIT  = 3
);
    logic                yzb_gecerli_o;
    logic [UOP_BIT-1:0]  yzb_kod_o;
    logic [VERI_BIT-1:0] yzb_islec1_o;
    logic [VERI_BIT-1:0] yzb_islec2_o;
    logic                yzb_gecerli_i;
    logic [VERI_BIT-1:0] yzb_sonuc_i;

    modport master (
        output yzb_gecerli_o,
        output yzb_kod_o,
        output yzb_islec1_o,
        output yzb_islec2_o,
        input  yzb_gecerli_i,
        input  yzb_sonuc_i
    );

    modport slave (
        input  yzb_gecerli_o,
        input  yzb_kod_o,
        input  yzb_islec1_o,
        input  yzb_islec2_o,
        output yzb_gecerli_i,
        output yzb_sonuc_i
    );
endinterface

// File: rtl/yzb_istek_sirayici.sv
// -----------------------------------------------------------------------------
// yzb_istek_sirayici
// Drives the dot-product unit's uop port for one command at a time. A command
// carries a vector length L; L (x,w) pairs then arrive on a ready/valid stream
// and are packed two at a time into LDX/LDW uops. The sequence is CLRX, CLRW,
// loads, RUN; RUN is held until the unit reports done, and the unit's result
// is returned on a ready/valid result port.
// Ports:
//   clk_i, rstn_i                        clock, synchronous active-low reset
//   komut_gecerli_i/_uzunluk_i/_hazir_o  command handshake, L
//   eleman_gecerli_i/_x_i/_w_i/_hazir_o  element pair stream
//   yzb (master modport)                 uop port to the unit
//   sonuc_o/_gecerli_o, sonuc_hazir_i    result handshake
// All outputs are registered.
// -----------------------------------------------------------------------------
module yzb_istek_sirayici #(
    parameter int VERI_BIT       = 32,
    parameter int CNN_YAZMAC_BIT = 4,
    parameter int UOP_BIT        = 3
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      komut_gecerli_i,
    input  logic [CNN_YAZMAC_BIT-1:0] komut_uzunluk_i,
    output logic                      komut_hazir_o,
    input  logic                      eleman_gecerli_i,
    input  logic [VERI_BIT-1:0]       eleman_x_i,
    input  logic [VERI_BIT-1:0]       eleman_w_i,
    output logic                      eleman_hazir_o,
    yzb_istek_sirayici_if.master      yzb,
    output logic [VERI_BIT-1:0]       sonuc_o,
    output logic                      sonuc_gecerli_o,
    input  logic                      sonuc_hazir_i
);

    // Unit uop codes (the codebase's UOP_YZB_* values).
    localparam logic [UOP_BIT-1:0] UOP_LDX_ALL = UOP_BIT'(3'd0);
    localparam logic [UOP_BIT-1:0] UOP_LDX_OP1 = UOP_BIT'(3'd1);
    localparam logic [UOP_BIT-1:0] UOP_LDW_ALL = UOP_BIT'(3'd2);
    localparam logic [UOP_BIT-1:0] UOP_LDW_OP1 = UOP_BIT'(3'd3);
    localparam logic [UOP_BIT-1:0] UOP_CLRX    = UOP_BIT'(3'd4);
    localparam logic [UOP_BIT-1:0] UOP_CLRW    = UOP_BIT'(3'd5);
    localparam logic [UOP_BIT-1:0] UOP_RUN     = UOP_BIT'(3'd6);

    typedef enum logic [2:0] {
        BOSTA     = 3'd0,
        TEMIZLE_X = 3'd1,
        TEMIZLE_W = 3'd2,
        TOPLA     = 3'd3,
        YUKLE_X   = 3'd4,
        YUKLE_W   = 3'd5,
        CALISTIR  = 3'd6,
        SONUC     = 3'd7
    } durum_t;

    durum_t                    durum_r;
    logic [CNN_YAZMAC_BIT-1:0] kalan_r;
    logic [1:0]                sayac_r;
    // Pair buffer: x1 goes straight into the LDX operand register, so only
    // x0, w0 and w1 need holding until their uops are issued.
    logic [VERI_BIT-1:0]       x0_r;
    logic [VERI_BIT-1:0]       w0_r;
    logic [VERI_BIT-1:0]       w1_r;

    logic                      komut_hazir_r;
    logic                      eleman_hazir_r;
    logic                      yzb_gecerli_r;
    logic [UOP_BIT-1:0]        yzb_kod_r;
    logic [VERI_BIT-1:0]       yzb_islec1_r;
    logic [VERI_BIT-1:0]       yzb_islec2_r;
    logic [VERI_BIT-1:0]       sonuc_r;
    logic                      sonuc_gecerli_r;

    logic                      uop_emekli_s;
    logic                      eleman_al_s;
    logic [1:0]                sayac_art_s;
    logic [1:0]                hedef_s;
    logic [CNN_YAZMAC_BIT-1:0] kalan_eksi_s;

    assign komut_hazir_o     = komut_hazir_r;
    assign eleman_hazir_o    = eleman_hazir_r;
    assign yzb.yzb_gecerli_o = yzb_gecerli_r;
    assign yzb.yzb_kod_o     = yzb_kod_r;
    assign yzb.yzb_islec1_o  = yzb_islec1_r;
    assign yzb.yzb_islec2_o  = yzb_islec2_r;
    assign sonuc_o           = sonuc_r;
    assign sonuc_gecerli_o   = sonuc_gecerli_r;

    // Handshake qualifiers and group bookkeeping for the next-state logic.
    always_comb begin
        uop_emekli_s = yzb_gecerli_r & yzb.yzb_gecerli_i;
        eleman_al_s  = eleman_hazir_r & eleman_gecerli_i;
        sayac_art_s  = sayac_r + 2'd1;
        kalan_eksi_s = kalan_r - CNN_YAZMAC_BIT'(sayac_r);
        // A group is two pairs unless only one element is left.
        if (kalan_r > CNN_YAZMAC_BIT'(1'b1)) begin
            hedef_s = 2'd2;
        end else begin
            hedef_s = 2'd1;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            durum_r         <= BOSTA;
            kalan_r         <= '0;
            sayac_r         <= 2'd0;
            x0_r            <= '0;
            w0_r            <= '0;
            w1_r            <= '0;
            komut_hazir_r   <= 1'b0;
            eleman_hazir_r  <= 1'b0;
            yzb_gecerli_r   <= 1'b0;
            yzb_kod_r       <= '0;
            yzb_islec1_r    <= '0;
            yzb_islec2_r    <= '0;
            sonuc_r         <= '0;
            sonuc_gecerli_r <= 1'b0;
        end else begin
            case (durum_r)
                BOSTA: begin
                    if (komut_hazir_r && komut_gecerli_i) begin
                        kalan_r       <= komut_uzunluk_i;
                        sayac_r       <= 2'd0;
                        komut_hazir_r <= 1'b0;
                        yzb_gecerli_r <= 1'b1;
                        yzb_kod_r     <= UOP_CLRX;
                        yzb_islec1_r  <= '0;
                        yzb_islec2_r  <= '0;
                        durum_r       <= TEMIZLE_X;
                    end else begin
                        komut_hazir_r <= 1'b1;
                    end
                end
                TEMIZLE_X: begin
                    if (uop_emekli_s) begin
                        yzb_kod_r <= UOP_CLRW;
                        durum_r   <= TEMIZLE_W;
                    end
                end
                TEMIZLE_W: begin
                    if (uop_emekli_s) begin
                        if (kalan_r == '0) begin
                            yzb_kod_r <= UOP_RUN;
                            durum_r   <= CALISTIR;
                        end else begin
                            yzb_gecerli_r  <= 1'b0;
                            eleman_hazir_r <= 1'b1;
                            durum_r        <= TOPLA;
                        end
                    end
                end
                TOPLA: begin
                    if (eleman_al_s) begin
                        sayac_r <= sayac_art_s;
                        if (sayac_r == 2'd0) begin
                            x0_r <= eleman_x_i;
                            w0_r <= eleman_w_i;
                        end else begin
                            w1_r <= eleman_w_i;
                        end
                        // Group complete: the LDX operands come partly from
                        // the pair being accepted right now.
                        if (sayac_art_s == hedef_s) begin
                            eleman_hazir_r <= 1'b0;
                            yzb_gecerli_r  <= 1'b1;
                            durum_r        <= YUKLE_X;
                            if (sayac_art_s == 2'd2) begin
                                yzb_kod_r    <= UOP_LDX_ALL;
                                yzb_islec1_r <= x0_r;
                                yzb_islec2_r <= eleman_x_i;
                            end else begin
                                yzb_kod_r    <= UOP_LDX_OP1;
                                yzb_islec1_r <= eleman_x_i;
                                yzb_islec2_r <= '0;
                            end
                        end
                    end
                end
                YUKLE_X: begin
                    if (uop_emekli_s) begin
                        durum_r      <= YUKLE_W;
                        yzb_islec1_r <= w0_r;
                        if (sayac_r == 2'd2) begin
                            yzb_kod_r    <= UOP_LDW_ALL;
                            yzb_islec2_r <= w1_r;
                        end else begin
                            yzb_kod_r    <= UOP_LDW_OP1;
                            yzb_islec2_r <= '0;
                        end
                    end
                end
                YUKLE_W: begin
                    if (uop_emekli_s) begin
                        kalan_r <= kalan_eksi_s;
                        sayac_r <= 2'd0;
                        if (kalan_eksi_s == '0) begin
                            yzb_kod_r    <= UOP_RUN;
                            yzb_islec1_r <= '0;
                            yzb_islec2_r <= '0;
                            durum_r      <= CALISTIR;
                        end else begin
                            yzb_gecerli_r  <= 1'b0;
                            eleman_hazir_r <= 1'b1;
                            durum_r        <= TOPLA;
                        end
                    end
                end
                CALISTIR: begin
                    // RUN stays asserted until the unit reports done.
                    if (uop_emekli_s) begin
                        yzb_gecerli_r   <= 1'b0;
                        yzb_kod_r       <= '0;
                        sonuc_r         <= yzb.yzb_sonuc_i;
                        sonuc_gecerli_r <= 1'b1;
                        durum_r         <= SONUC;
                    end
                end
                SONUC: begin
                    // komut_hazir rises with the return to BOSTA, so a new
                    // command is taken no earlier than the following cycle.
                    if (sonuc_hazir_i) begin
                        sonuc_gecerli_r <= 1'b0;
                        komut_hazir_r   <= 1'b1;
                        durum_r         <= BOSTA;
                    end
                end
                default: begin
                    durum_r         <= BOSTA;
                    komut_hazir_r   <= 1'b0;
                    eleman_hazir_r  <= 1'b0;
                    yzb_gecerli_r   <= 1'b0;
                    sonuc_gecerli_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
